// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one Uart8 transmitter between NUM_REQ byte-stream
// requesters. Round-robin arbitration with packet locking: the owner keeps
// the UART until it flags a last byte, reaches BURST_MAX bytes, or leaves
// reqValid low for GAP_TIMEOUT cycles while waiting to send.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_MAX   = 16,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [8*NUM_REQ-1:0]   reqData,
  input  logic [NUM_REQ-1:0]     reqLast,
  output logic [NUM_REQ-1:0]     reqReady,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   txEn,
  output logic                   txStart,
  output logic [7:0]             txIn,
  input  logic                   txBusy,
  input  logic                   txDone,
  output logic                   busy
);

  localparam int         PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] BURST_LIMIT = 8'(BURST_MAX);
  // Last gap count before revocation: the revoking cycle is the
  // GAP_TIMEOUT-th consecutive idle cycle of the owner.
  localparam logic [7:0] GAP_LIMIT   = 8'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e             state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [PTR_W-1:0]   owner_q,    owner_d;
  logic [PTR_W-1:0]   ptr_q,      ptr_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         gap_cnt_q,  gap_cnt_d;
  logic               last_q,     last_d;
  logic [7:0]         tx_in_q,    tx_in_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_en_q,    tx_en_d;

  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  // Observe only the current owner's request lines.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        sel_valid = reqValid[i];
        sel_last  = reqLast[i];
        sel_data  = reqData[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first valid requester above the pointer, then wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && reqValid[i] && (i > int'(ptr_q))) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && reqValid[i] && (i <= int'(ptr_q))) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
  end

  // Next-state logic: grant, byte acceptance and UART handshake sequencing.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_d     = last_q;
    tx_in_d    = tx_in_q;
    tx_start_d = tx_start_q;
    tx_en_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = NUM_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (sel_valid) begin
          tx_in_d    = sel_data;
          last_d     = sel_last;
          byte_cnt_d = byte_cnt_q + 8'd1;
          gap_cnt_d  = '0;
          tx_start_d = 1'b1;
          state_d    = WAIT_BUSY;
        end else if (gap_cnt_q >= GAP_LIMIT) begin
          // Owner went quiet too long: release so others can proceed.
          grant_d    = '0;
          ptr_d      = owner_q;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          gap_cnt_d  = gap_cnt_q + 8'd1;
        end
      end

      WAIT_BUSY: begin
        // txStart stays up until the UART confirms it has taken the byte.
        if (txBusy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (txDone) begin
          if (last_q || (byte_cnt_q >= BURST_LIMIT)) begin
            grant_d    = '0;
            ptr_d      = owner_q;
            byte_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            state_d    = SEND;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b0;
      tx_in_q    <= '0;
      tx_start_q <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      tx_in_q    <= tx_in_d;
      tx_start_q <= tx_start_d;
      tx_en_q    <= tx_en_d;
    end
  end

  // Ready is a pure decode of registered state, never of reqValid.
  assign reqReady = (state_q == SEND) ? grant_q : '0;
  assign grant    = grant_q;
  assign busy     = |grant_q;
  assign txEn     = tx_en_q;
  assign txStart  = tx_start_q;
  assign txIn     = tx_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester queues, a Uart8 responder (automatic or
// hand-driven), arbitration vector table, directed corner sequences and
// randomized streams checked against a queue-level reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int BURST_MAX   = 16;
  localparam int GAP_TIMEOUT = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] g;
    logic [7:0]         d;
  } cap_t;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] first;
    logic [NUM_REQ-1:0] second;
  } vec_t;

  logic                 clk;
  logic                 rstN;
  logic [NUM_REQ-1:0]   reqValid;
  logic [8*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]   reqLast;
  logic [NUM_REQ-1:0]   reqReady;
  logic [NUM_REQ-1:0]   grant;
  logic                 txEn;
  logic                 txStart;
  logic [7:0]           txIn;
  logic                 txBusy;
  logic                 txDone;
  logic                 busy;

  logic auto_uart = 1'b0;
  logic m_busy    = 1'b0;
  logic m_done    = 1'b0;
  logic man_busy  = 1'b0;
  logic man_done  = 1'b0;

  assign txBusy = auto_uart ? m_busy : man_busy;
  assign txDone = auto_uart ? m_done : man_done;

  byte_t rq [NUM_REQ][$];
  cap_t  cap_q[$];
  cap_t  exp_q[$];

  int total = 0;
  int bad   = 0;
  int idle_run      = 0;
  int last_idle_run = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .BURST_MAX  (BURST_MAX),
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rstN    (rstN),
    .reqValid(reqValid),
    .reqData (reqData),
    .reqLast (reqLast),
    .reqReady(reqReady),
    .grant   (grant),
    .txEn    (txEn),
    .txStart (txStart),
    .txIn    (txIn),
    .txBusy  (txBusy),
    .txDone  (txDone),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Length of the most recent run of cycles with no owner.
  always @(negedge clk) begin
    if (grant == '0) idle_run <= idle_run + 1;
    else begin
      if (idle_run != 0) last_idle_run <= idle_run;
      idle_run <= 0;
    end
  end

  // Requester side: present queue heads, pop on handshake.
  initial begin : req_driver
    logic [NUM_REQ-1:0] hs;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
    forever begin
      @(negedge clk);
      hs = reqValid & reqReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        reqValid[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          reqData[8*i +: 8] = rq[i][0].data;
          reqLast[i]        = rq[i][0].last;
        end
      end
    end
  end

  // Automatic Uart8 responder: random start latency and frame length.
  initial begin : uart_model
    int d;
    forever begin
      @(negedge clk);
      if (auto_uart && rstN && txStart) begin
        cap_q.push_back('{g: grant, d: txIn});
        d = $urandom_range(0, 2);
        repeat (d + 1) @(posedge clk);
        #1 m_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 m_busy = 1'b0;
        m_done = 1'b1;
        @(posedge clk);
        #1 m_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input logic [7:0] data, input logic last);
    rq[r].push_back('{data: data, last: last});
  endtask

  task automatic do_reset(input logic auto_mode);
    rstN      = 1'b0;
    man_busy  = 1'b0;
    man_done  = 1'b0;
    auto_uart = auto_mode;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    cap_q.delete();
    exp_q.delete();
    tick(2);
    rstN = 1'b1;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int c = 0;
    while (c < budget && !(all_empty() && !busy && !txBusy && !txStart)) begin
      tick(1);
      c++;
    end
    if (c >= budget) check({tag, "_timeout"}, 32'(c), 32'(0));
    tick(2);
  endtask

  task automatic compare_caps(input string tag);
    check({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check({tag, "_grant"}, 32'(cap_q[i].g), 32'(exp_q[i].g));
      check({tag, "_data"},  32'(cap_q[i].d), 32'(exp_q[i].d));
    end
  endtask

  // Reference: replay queues as whole grants in round-robin order.
  task automatic build_model();
    byte_t mq [NUM_REQ][$];
    byte_t b;
    int    ptr = NUM_REQ - 1;
    int    g;
    int    n;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = rq[i];
    exp_q.delete();
    while (1) begin
      g = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (g < 0 && mq[(ptr + k) % NUM_REQ].size() > 0) g = (ptr + k) % NUM_REQ;
      end
      if (g < 0) break;
      n = 0;
      do begin
        b = mq[g].pop_front();
        exp_q.push_back('{g: NUM_REQ'(1) << g, d: b.data});
        n++;
      end while (!b.last && n < BURST_MAX && mq[g].size() > 0);
      ptr = g;
    end
  endtask

  initial begin : main
    vec_t tbl [7];
    int   gap;
    bit   seen;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0101, 4'b0001, 4'b0100};
    tbl[2] = '{4'b1010, 4'b0010, 4'b1000};
    tbl[3] = '{4'b1100, 4'b0100, 4'b1000};
    tbl[4] = '{4'b1001, 4'b0001, 4'b1000};
    tbl[5] = '{4'b1111, 4'b0001, 4'b0010};
    tbl[6] = '{4'b1000, 4'b1000, 4'b0000};

    // Reset values.
    rstN = 1'b0;
    tick(2);
    check("rst_grant",   32'(grant),    32'(0));
    check("rst_ready",   32'(reqReady), 32'(0));
    check("rst_txstart", 32'(txStart),  32'(0));
    check("rst_txen",    32'(txEn),     32'(0));
    check("rst_busy",    32'(busy),     32'(0));
    check("rst_txin",    32'(txIn),     32'(0));
    rstN = 1'b1;
    tick(1);
    check("txen_after_rst", 32'(txEn), 32'(1));

    // Single byte from requester 0 with hand-driven UART.
    push(0, 8'hD6, 1'b1);
    tick(2);
    check("t1_grant",   32'(grant),    32'(4'b0001));
    check("t1_ready",   32'(reqReady), 32'(4'b0001));
    check("t1_busy",    32'(busy),     32'(1));
    tick(1);
    check("t1_ready_pulse", 32'(reqReady), 32'(0));
    check("t1_txstart",     32'(txStart),  32'(1));
    check("t1_txin",        32'(txIn),     32'(8'hD6));
    tick(2);
    check("t1_start_hold",  32'(txStart),  32'(1));
    man_busy = 1'b1;
    tick(1);
    check("t1_start_drop",  32'(txStart),  32'(0));
    check("t1_grant_held",  32'(grant),    32'(4'b0001));
    man_busy = 1'b0;
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    check("t1_released", 32'(grant), 32'(0));
    check("t1_idle",     32'(busy),  32'(0));

    // txBusy already high at start; stray txDone while in SEND.
    do_reset(1'b0);
    man_busy = 1'b1;
    push(0, 8'h5A, 1'b0);
    tick(2);
    check("t5_grant", 32'(grant), 32'(4'b0001));
    tick(1);
    check("t5_start1", 32'(txStart), 32'(1));
    check("t5_txin1",  32'(txIn),    32'(8'h5A));
    tick(1);
    check("t5_start_one_cycle", 32'(txStart), 32'(0));
    man_busy = 1'b0;
    man_done = 1'b1;
    tick(1);
    check("t5_back_send", 32'(reqReady), 32'(4'b0001));
    tick(1);
    man_done = 1'b0;
    check("t5_stray_done_ready", 32'(reqReady), 32'(4'b0001));
    check("t5_stray_done_grant", 32'(grant),    32'(4'b0001));
    check("t5_stray_done_start", 32'(txStart),  32'(0));
    push(0, 8'hA5, 1'b1);
    man_busy = 1'b1;
    tick(2);
    check("t5_start2", 32'(txStart), 32'(1));
    check("t5_txin2",  32'(txIn),    32'(8'hA5));
    tick(1);
    check("t5_start2_one_cycle", 32'(txStart), 32'(0));
    man_busy = 1'b0;
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    check("t5_released", 32'(grant), 32'(0));

    // Reset during WAIT_DONE restores the pointer to NUM_REQ-1.
    do_reset(1'b0);
    push(1, 8'h31, 1'b1);
    tick(3);
    check("t6_grant1", 32'(grant), 32'(4'b0010));
    man_busy = 1'b1;
    tick(1);
    man_busy = 1'b0;
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    push(2, 8'h42, 1'b0);
    tick(3);
    check("t6_grant2",  32'(grant),   32'(4'b0100));
    check("t6_start2",  32'(txStart), 32'(1));
    man_busy = 1'b1;
    tick(1);
    push(0, 8'h50, 1'b1);
    push(2, 8'h43, 1'b1);
    #2 rstN = 1'b0;
    #1;
    check("t6_async_grant", 32'(grant),    32'(0));
    check("t6_async_start", 32'(txStart),  32'(0));
    check("t6_async_ready", 32'(reqReady), 32'(0));
    check("t6_async_busy",  32'(busy),     32'(0));
    man_busy = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(1);
    check("t6_ptr_reset_winner", 32'(grant), 32'(4'b0001));

    // Arbitration table from a fresh reset.
    for (int v = 0; v < 7; v++) begin
      do_reset(1'b1);
      for (int i = 0; i < NUM_REQ; i++)
        if (tbl[v].mask[i]) push(i, 8'(16 * v + i), 1'b1);
      wait_quiet("tbl", 400);
      check("tbl_first",  32'(cap_q.size() > 0 ? cap_q[0].g : '0), 32'(tbl[v].first));
      check("tbl_second", 32'(cap_q.size() > 1 ? cap_q[1].g : '0), 32'(tbl[v].second));
    end

    // Requesters 0 and 2 contend twice; released owner loses the rematch.
    do_reset(1'b1);
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    exp_q = '{'{4'b0001, 8'hA0}, '{4'b0001, 8'hA1}, '{4'b0100, 8'hC0}, '{4'b0100, 8'hC1}};
    wait_quiet("t2a", 600);
    compare_caps("t2a");
    check("t2_one_idle_cycle", 32'(last_idle_run), 32'(1));
    cap_q.delete();
    push(0, 8'hA2, 1'b1);
    push(2, 8'hC2, 1'b1);
    exp_q = '{'{4'b0001, 8'hA2}, '{4'b0100, 8'hC2}};
    wait_quiet("t2b", 600);
    compare_caps("t2b");

    // Burst limit: requester 1 sends 20 unterminated bytes, 3 waits.
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) push(1, 8'(8'h60 + i), 1'b0);
    push(3, 8'h33, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back('{4'b0010, 8'(8'h60 + i)});
    exp_q.push_back('{4'b1000, 8'h33});
    for (int i = 16; i < 20; i++) exp_q.push_back('{4'b0010, 8'(8'h60 + i)});
    wait_quiet("t3", 3000);
    compare_caps("t3");

    // Gap timeout: owner 0 goes silent after two bytes, 1 is waiting.
    do_reset(1'b1);
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0);
    push(1, 8'hE0, 1'b1);
    gap  = 0;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick(1);
      if (grant == 4'b0001) seen = 1'b1;
      if (reqReady == 4'b0001) gap = reqValid[0] ? 0 : gap + 1;
      if (seen && grant == '0) break;
    end
    check("t4_revoked",  32'(grant), 32'(0));
    check("t4_gap_len",  32'(gap),   32'(GAP_TIMEOUT));
    tick(1);
    check("t4_next_owner", 32'(grant), 32'(4'b0010));
    exp_q = '{'{4'b0001, 8'hB0}, '{4'b0001, 8'hB1}, '{4'b0010, 8'hE0}};
    wait_quiet("t4", 600);
    compare_caps("t4");

    // Randomized streams against the queue-level model.
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b1);
      for (int i = 0; i < NUM_REQ; i++) begin
        int n = $urandom_range(0, 24);
        for (int j = 0; j < n; j++) push(i, 8'($urandom), ($urandom_range(0, 3) == 0));
      end
      build_model();
      wait_quiet("rand", 20000);
      compare_caps("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one Uart8 transmitter between NUM_REQ byte-stream requesters (e.g. command echo, status reporter, debug dump).
- Arbitration is round-robin with packet locking: the granted requester keeps the UART until it flags its last byte, hits BURST_MAX bytes, or idles past GAP_TIMEOUT.
- Sits between requester logic and the Uart8 tx interface, sequencing txStart/txIn against txBusy/txDone.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BURST_MAX, 16: maximum bytes per grant before forced re-arbitration (1..255).
- GAP_TIMEOUT, 64: clk cycles the granted requester may leave reqValid low mid-packet before its grant is revoked (1..255).

Ports:
- clk  in  1  system clock.
- rstN  in  1  asynchronous active-low reset.
- reqValid  in  NUM_REQ  per-requester byte valid.
- reqData  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- reqLast  in  NUM_REQ  byte is last of packet; qualified by valid&ready.
- reqReady  out  NUM_REQ  byte accepted when reqValid[i]&reqReady[i].
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- txEn  out  1  Uart8 tx enable.
- txStart  out  1  Uart8 start request.
- txIn  out  8  byte to Uart8.
- txBusy  in  1  Uart8 transmitting.
- txDone  in  1  Uart8 one-cycle completion pulse.
- busy  out  1  high whenever grant is non-zero.

Behaviour:
- Reset (rstN low, async): state IDLE; grant, reqReady, txStart, busy = 0; txIn = 0; txEn = 0; rr pointer = NUM_REQ-1; byte and gap counters = 0.
- txEn rises to 1 on the first clk after reset release and stays 1.
- IDLE:
  - If any reqValid is high, choose the first set bit scanning from pointer+1 upward with wrap.
  - Register grant one-hot; go to SEND.
  - Grant is visible 1 cycle after reqValid.
- SEND:
  - reqReady[i] = grant[i] (decode of registered state; no combinational dependence on reqValid).
  - On reqValid[g]: latch data into txIn and reqLast into lastQ; increment the byte counter; clear the gap counter; set txStart=1 next cycle; go to WAIT_BUSY.
  - If reqValid[g] is low: increment the gap counter. At GAP_TIMEOUT, release (grant=0, pointer=g) and go to IDLE.
- WAIT_BUSY:
  - Hold txStart=1 and keep txIn stable until txBusy is sampled high.
  - Then txStart=0; go to WAIT_DONE.
- WAIT_DONE:
  - On txDone, release (grant=0, pointer=g, counters cleared, IDLE) if lastQ or byte counter==BURST_MAX.
  - Otherwise return to SEND.
- Release-then-rearbitrate costs one IDLE cycle. The released owner has lowest priority in that arbitration.
- reqReady is low in every state except SEND; exactly one byte is accepted per UART frame.
- Only grant owner's inputs are observed; non-granted reqValid/reqData changes are ignored.
- txDone outside WAIT_DONE is ignored; txBusy already high on SEND→WAIT_BUSY is accepted on the first sample (txStart high exactly 1 cycle).
- Byte counter 8-bit, saturating compare at BURST_MAX; gap counter 8-bit, cleared on each accepted byte and on release.
- Reset mid-frame: all outputs return to reset values immediately. The in-flight byte is abandoned and no reqReady is reissued.

Test Plan:
- Single requester 0 sends 0xD6 with reqLast=1 → grant=0001 one cycle later; reqReady pulse 1 cycle; txIn=0xD6, txStart held until txBusy; after txDone grant=0000, busy=0.
- Requesters 0 and 2 both valid from idle after reset → grant 0001 first; on its last byte, grant 0100 after one IDLE cycle; next contention with 0 and 2 again → 2 is skipped past, 0 wins.
- Requester 1 sends 20 bytes, never sets reqLast, BURST_MAX=16 with requester 3 waiting → exactly 16 bytes accepted, then grant moves to 3; requester 1 regains the UART afterwards for its remaining 4 bytes.
- Requester 0 granted, drops reqValid after 2 bytes for 100 cycles (GAP_TIMEOUT=64) → grant revoked at gap cycle 64; requester 1 valid is granted next.
- txBusy already high when entering WAIT_BUSY → txStart high exactly one cycle; txDone pulse injected during SEND is ignored (no extra byte, no release).
- rstN asserted during WAIT_DONE → grant, txStart, reqReady, busy drop asynchronously to 0; after release, pointer=NUM_REQ-1 so requester 0 wins the first contention.
